// File: rtl/tdsp_ds_buffer_pkg.sv
// tdsp_ds_buffer_pkg: shared TDSP data width and data-sample buffer geometry.
package tdsp_ds_buffer_pkg;
    localparam int MSB          = 15;
    localparam int DS_DEPTH     = 8;
    localparam int DS_AW        = 3;
    localparam int DS_IRQ_LEVEL = 4;
endpackage

// File: rtl/tdsp_ds_buffer_ptr.sv
// tdsp_ds_ptr: AW-bit wrapping pointer with increment enable and async active-low clear.
module tdsp_ds_ptr #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_inc,
    output logic [AW-1:0] o_ptr
);
    logic [AW-1:0] r_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   r_ptr <= '0;
        else if (i_inc) r_ptr <= r_ptr + 1'b1;
    end

    assign o_ptr = r_ptr;
endmodule

// File: rtl/tdsp_ds_buffer.sv
// tdsp_ds_buffer: show-ahead sample FIFO feeding the TDSP data mux, with level irq
// and sticky overflow/underflow status.
module tdsp_ds_buffer
    import tdsp_ds_buffer_pkg::*;
#(
    parameter int DEPTH     = DS_DEPTH,
    parameter int AW        = DS_AW,
    parameter int IRQ_LEVEL = DS_IRQ_LEVEL
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [MSB:0] sample_in,
    input  logic         sample_stb,
    input  logic         ds_read,
    output logic [MSB:0] ds_data,
    output logic [AW:0]  ds_count,
    output logic         ds_empty,
    output logic         ds_full,
    output logic         ds_irq,
    output logic         ovf,
    output logic         unf,
    input  logic         flag_clr
);
    logic [MSB:0]  r_mem [0:DEPTH-1];
    logic [AW:0]   r_count;
    logic          r_ovf;
    logic          r_unf;
    logic [AW-1:0] w_wp;
    logic [AW-1:0] w_rp;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;

    assign w_empty = r_count == '0;
    assign w_full  = r_count == (AW+1)'(DEPTH);
    assign w_pop   = ds_read && !w_empty;
    // a pop frees a slot in the same edge, so a full buffer still accepts a strobe
    assign w_push  = sample_stb && (!w_full || w_pop);

    tdsp_ds_ptr #(.AW(AW)) u_wp (.clk(clk), .reset_n(reset_n), .i_inc(w_push), .o_ptr(w_wp));
    tdsp_ds_ptr #(.AW(AW)) u_rp (.clk(clk), .reset_n(reset_n), .i_inc(w_pop),  .o_ptr(w_rp));

    always_ff @(posedge clk) begin
        if (w_push) r_mem[w_wp] <= sample_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (sample_stb && w_full && !w_pop) r_ovf <= 1'b1;
            else if (flag_clr)                  r_ovf <= 1'b0;
            if (ds_read && w_empty)             r_unf <= 1'b1;
            else if (flag_clr)                  r_unf <= 1'b0;
        end
    end

    assign ds_data  = w_empty ? '0 : r_mem[w_rp];
    assign ds_count = r_count;
    assign ds_empty = w_empty;
    assign ds_full  = w_full;
    assign ds_irq   = r_count >= (AW+1)'(IRQ_LEVEL);
    assign ovf      = r_ovf;
    assign unf      = r_unf;
endmodule

// File: tb/tb_tdsp_ds_buffer.sv
// tb_tdsp_ds_buffer: directed and randomized checks of tdsp_ds_buffer against a queue model.
module tb_tdsp_ds_buffer;
    logic        clk;
    logic        reset_n;
    logic [15:0] sample_in;
    logic        sample_stb;
    logic        ds_read;
    logic [15:0] ds_data;
    logic [3:0]  ds_count;
    logic        ds_empty;
    logic        ds_full;
    logic        ds_irq;
    logic        ovf;
    logic        unf;
    logic        flag_clr;

    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] q[$];
    logic        m_ovf = 0;
    logic        m_unf = 0;

    tdsp_ds_buffer dut (
        .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_stb(sample_stb),
        .ds_read(ds_read), .ds_data(ds_data), .ds_count(ds_count), .ds_empty(ds_empty),
        .ds_full(ds_full), .ds_irq(ds_irq), .ovf(ovf), .unf(unf), .flag_clr(flag_clr)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, ".count"}, 32'(ds_count), 32'(q.size()));
        check({tag, ".empty"}, 32'(ds_empty), 32'(q.size() == 0));
        check({tag, ".full"},  32'(ds_full),  32'(q.size() == 8));
        check({tag, ".irq"},   32'(ds_irq),   32'(q.size() >= 4));
        check({tag, ".ovf"},   32'(ovf),      32'(m_ovf));
        check({tag, ".unf"},   32'(unf),      32'(m_unf));
        check({tag, ".data"},  32'(ds_data),  32'(q.size() != 0 ? q[0] : 16'h0000));
    endtask

    task automatic step(input logic stb, input logic [15:0] din, input logic rd, input logic clr);
        logic pop, push, oset, uset;
        sample_stb = stb;
        sample_in  = din;
        ds_read    = rd;
        flag_clr   = clr;
        #1;
        check("head", 32'(ds_data), 32'(q.size() != 0 ? q[0] : 16'h0000));
        pop  = rd && q.size() != 0;
        push = stb && (q.size() < 8 || pop);
        oset = stb && q.size() == 8 && !pop;
        uset = rd && q.size() == 0;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (push) q.push_back(din);
        m_ovf = oset ? 1'b1 : clr ? 1'b0 : m_ovf;
        m_unf = uset ? 1'b1 : clr ? 1'b0 : m_unf;
        #1;
        check_status("post");
    endtask

    task automatic do_reset();
        sample_stb = 0; ds_read = 0; flag_clr = 0; sample_in = 0;
        reset_n = 0;
        #1;
        q.delete();
        m_ovf = 0;
        m_unf = 0;
        check_status("rst");
        #2 reset_n = 1;
        @(posedge clk);
        #1;
        check_status("rst_rel");
    endtask

    initial begin
        reset_n = 1; sample_stb = 0; ds_read = 0; flag_clr = 0; sample_in = 0;
        #2 do_reset();
        for (int i = 0; i < 3; i++) step(0, 16'h0, 0, 0);
        step(1, 16'hA5A5, 0, 0);
        check("a5_data", 32'(ds_data), 32'h0000A5A5);
        step(0, 16'h0, 1, 0);
        for (int i = 1; i <= 8; i++) step(1, 16'(i), 0, 0);
        for (int i = 1; i <= 8; i++) begin
            check("drain_seq", 32'(ds_data), 32'(i));
            step(0, 16'h0, 1, 0);
        end
        for (int i = 1; i <= 8; i++) step(1, 16'(16'h10 + i), 0, 0);
        step(1, 16'hDEAD, 0, 0);
        check("ovf_set", 32'(ovf), 32'h1);
        for (int i = 0; i < 9; i++) begin
            check("no_dead", 32'(ds_data == 16'hDEAD), 32'h0);
            step(0, 16'h0, 1, 0);
        end
        step(0, 16'h0, 0, 1);
        check("ovf_clr", 32'(ovf), 32'h0);
        step(0, 16'h0, 1, 0);
        step(1, 16'h1234, 0, 0);
        step(0, 16'h0, 1, 1);
        for (int i = 0; i < 8; i++) step(1, 16'(16'h20 + i), 0, 0);
        step(1, 16'hBEEF, 1, 0);
        check("full_both_ovf", 32'(ovf), 32'h0);
        for (int i = 0; i < 8; i++) step(0, 16'h0, 1, 0);
        step(1, 16'h5555, 1, 0);
        check("empty_both_cnt", 32'(ds_count), 32'h1);
        step(0, 16'h0, 1, 1);
        for (int i = 0; i < 20; i++) step(1, 16'(16'h300 + i), (i % 4) != 3, 0);
        step(1, 16'h0400, 0, 0);
        do_reset();
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 99) < 55, 16'($urandom), $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 8);
        for (int i = 0; i < 12; i++) step(1, 16'($urandom), 0, 0);
        do_reset();
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 1) == 1, 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
